// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register bank write port,
// plus the destination scoreboard that tracks pending writebacks.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst_async,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*IDX_W-1:0]  req_index,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      claim_valid,
  input  logic [IDX_W-1:0]          claim_index,
  output logic                      claim_ready,
  output logic                      write_en,
  output logic [IDX_W-1:0]          write_index,
  output logic [DATA_W-1:0]         write,
  output logic [2**IDX_W-1:0]       busy
);

  localparam int NREG  = 2**IDX_W;
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]  rr_ptr_q;
  logic [PTR_W-1:0]  rr_ptr_d;
  logic [PTR_W-1:0]  win;
  logic              found;
  logic [IDX_W-1:0]  sel_idx;
  logic [DATA_W-1:0] sel_data;

  logic              write_en_q;
  logic [IDX_W-1:0]  write_index_q;
  logic [DATA_W-1:0] write_q;
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  // Pick the first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        win   = PTR_W'(j);
      end
    end
    if (rst_async) found = 1'b0;
  end

  // One-hot ready, selected payload and next pointer.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = found && (int'(win) == i);
    end
    sel_idx  = req_index[int'(win)*IDX_W +: IDX_W];
    sel_data = req_data[int'(win)*DATA_W +: DATA_W];
    rr_ptr_d = rr_ptr_q;
    if (found) begin
      if (win == PTR_W'(NUM_REQ-1)) rr_ptr_d = '0;
      else                          rr_ptr_d = win + 1'b1;
    end
  end

  // Release on bank write, then claim; claim wins a same-edge tie.
  always_comb begin
    busy_d = busy_q;
    if (write_en_q) busy_d[write_index_q] = 1'b0;
    if (claim_valid && claim_ready && claim_index != '0)
      busy_d[claim_index] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Claims stall on a pending register; r0 is never tracked.
  assign claim_ready = !rst_async &&
                       (claim_index == '0 || !busy_q[claim_index]);

  // Round-robin pointer advances past each granted requester.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) rr_ptr_q <= '0;
    else           rr_ptr_q <= rr_ptr_d;
  end

  // Registered write port; r0 accepts are swallowed.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      write_en_q    <= 1'b0;
      write_index_q <= '0;
      write_q       <= '0;
    end else if (found) begin
      write_en_q    <= (sel_idx != '0);
      write_index_q <= sel_idx;
      write_q       <= sel_data;
    end else begin
      write_en_q    <= 1'b0;
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) busy_q <= '0;
    else           busy_q <= busy_d;
  end

  assign write_en    = write_en_q;
  assign write_index = write_index_q;
  assign write       = write_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table with a write
// scoreboard, plus hand sequences for reset behaviour.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_async;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_index;
  logic [63:0] req_data;
  logic        claim_valid;
  logic [3:0]  claim_index;
  logic        claim_ready;
  logic        write_en;
  logic [3:0]  write_index;
  logic [31:0] write;
  logic [15:0] busy;

  int checks   = 0;
  int failures = 0;

  regfile_wb_arbiter #(.NUM_REQ(2), .DATA_W(32), .IDX_W(4)) dut (
    .clk         (clk),
    .rst_async   (rst_async),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_index   (req_index),
    .req_data    (req_data),
    .claim_valid (claim_valid),
    .claim_index (claim_index),
    .claim_ready (claim_ready),
    .write_en    (write_en),
    .write_index (write_index),
    .write       (write),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v;
    logic [3:0]  i0;
    logic [31:0] d0;
    logic [3:0]  i1;
    logic [31:0] d1;
    logic        cv;
    logic [3:0]  ci;
    logic [1:0]  rdy;
    logic        cr;
    logic [15:0] busy;
  } vec_t;

  typedef struct {
    logic        en;
    logic [3:0]  idx;
    logic [31:0] data;
  } wr_t;

  vec_t vecs[17];
  wr_t  exp_q[$];

  function automatic vec_t mk(
    input logic [1:0] v, input logic [3:0] i0, input logic [31:0] d0,
    input logic [3:0] i1, input logic [31:0] d1,
    input logic cv, input logic [3:0] ci,
    input logic [1:0] rdy, input logic cr, input logic [15:0] b);
    vec_t r;
    r.v = v; r.i0 = i0; r.d0 = d0; r.i1 = i1; r.d1 = d1;
    r.cv = cv; r.ci = ci; r.rdy = rdy; r.cr = cr; r.busy = b;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t t, input int n);
    wr_t w;
    wr_t e;
    @(negedge clk);
    req_valid   = t.v;
    req_index   = {t.i1, t.i0};
    req_data    = {t.d1, t.d0};
    claim_valid = t.cv;
    claim_index = t.ci;
    #1;
    chk($sformatf("v%0d req_ready", n), 64'(req_ready), 64'(t.rdy));
    chk($sformatf("v%0d claim_ready", n), 64'(claim_ready), 64'(t.cr));
    w.en = 1'b0; w.idx = '0; w.data = '0;
    if (t.rdy == 2'b01) begin
      w.en = (t.i0 != 0); w.idx = t.i0; w.data = t.d0;
    end else if (t.rdy == 2'b10) begin
      w.en = (t.i1 != 0); w.idx = t.i1; w.data = t.d1;
    end
    exp_q.push_back(w);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk($sformatf("v%0d scoreboard empty", n), 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d write_en", n), 64'(write_en), 64'(e.en));
      if (e.en) begin
        chk($sformatf("v%0d write_index", n), 64'(write_index), 64'(e.idx));
        chk($sformatf("v%0d write", n), 64'(write), 64'(e.data));
      end
    end
    chk($sformatf("v%0d busy", n), 64'(busy), 64'(t.busy));
  endtask

  initial begin
    //           v     i0  d0            i1  d1     cv  ci  rdy   cr  busy
    vecs[0]  = mk(2'b01, 3, 32'hDEADBEEF, 0, 0,     0, 0, 2'b01, 1, 16'h0000);
    vecs[1]  = mk(2'b00, 0, 0,            0, 0,     0, 0, 2'b00, 1, 16'h0000);
    vecs[2]  = mk(2'b11, 1, 32'hA1,       2, 32'hB2, 0, 0, 2'b10, 1, 16'h0000);
    vecs[3]  = mk(2'b11, 1, 32'hA3,       2, 32'hB3, 0, 0, 2'b01, 1, 16'h0000);
    vecs[4]  = mk(2'b11, 1, 32'hA4,       2, 32'hB4, 0, 0, 2'b10, 1, 16'h0000);
    vecs[5]  = mk(2'b11, 1, 32'hA5,       2, 32'hB5, 0, 0, 2'b01, 1, 16'h0000);
    vecs[6]  = mk(2'b00, 0, 0,            0, 0,     1, 5, 2'b00, 1, 16'h0020);
    vecs[7]  = mk(2'b00, 0, 0,            0, 0,     1, 5, 2'b00, 0, 16'h0020);
    vecs[8]  = mk(2'b01, 5, 32'h55,       0, 0,     0, 0, 2'b01, 1, 16'h0020);
    vecs[9]  = mk(2'b00, 0, 0,            0, 0,     1, 5, 2'b00, 0, 16'h0000);
    vecs[10] = mk(2'b00, 0, 0,            0, 0,     1, 5, 2'b00, 1, 16'h0020);
    vecs[11] = mk(2'b01, 7, 32'h77,       0, 0,     0, 0, 2'b01, 1, 16'h0020);
    vecs[12] = mk(2'b00, 0, 0,            0, 0,     1, 7, 2'b00, 1, 16'h00A0);
    vecs[13] = mk(2'b01, 0, 32'h1234,     0, 0,     0, 0, 2'b01, 1, 16'h00A0);
    vecs[14] = mk(2'b00, 0, 0,            0, 0,     1, 0, 2'b00, 1, 16'h00A0);
    vecs[15] = mk(2'b10, 0, 0,            7, 32'h70, 0, 0, 2'b10, 1, 16'h00A0);
    vecs[16] = mk(2'b00, 0, 0,            0, 0,     0, 0, 2'b00, 1, 16'h0020);

    rst_async   = 1'b1;
    req_valid   = 2'b11;
    req_index   = {4'd2, 4'd1};
    req_data    = 64'h1;
    claim_valid = 1'b1;
    claim_index = 4'd4;
    #12;
    chk("reset write_en", 64'(write_en), 64'd0);
    chk("reset write_index", 64'(write_index), 64'd0);
    chk("reset write", 64'(write), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset claim_ready", 64'(claim_ready), 64'd0);
    @(negedge clk);
    req_valid   = 2'b00;
    claim_valid = 1'b0;
    claim_index = 4'd0;
    rst_async   = 1'b0;

    for (int n = 0; n < 17; n++) step(vecs[n], n);

    // Mid-traffic reset: pointer would favour req1 without it.
    @(negedge clk);
    req_valid   = 2'b11;
    req_index   = {4'd2, 4'd1};
    req_data    = {32'hB0, 32'hA0};
    claim_valid = 1'b1;
    claim_index = 4'd9;
    @(posedge clk);
    #1;
    chk("pre-reset write_en", 64'(write_en), 64'd1);
    chk("pre-reset busy", 64'(busy), 64'h0220);
    #2;
    rst_async = 1'b1;
    #1;
    chk("midrst write_en", 64'(write_en), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst req_ready", 64'(req_ready), 64'd0);
    chk("midrst claim_ready", 64'(claim_ready), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("held rst write_en", 64'(write_en), 64'd0);
    @(negedge clk);
    claim_valid = 1'b0;
    rst_async   = 1'b0;
    #1;
    chk("post-rst req_ready", 64'(req_ready), 64'b01);
    @(posedge clk);
    #1;
    chk("post-rst write_en", 64'(write_en), 64'd1);
    chk("post-rst write_index", 64'(write_index), 64'd1);
    chk("post-rst write", 64'(write), 64'hA0);
    chk("post-rst busy", 64'(busy), 64'd0);
    @(negedge clk);
    req_valid = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
